shift_reg_seq: RTL and testbench
================================

# shift_reg_seq

Parametrised successor to the datapath shift register: a WIDTH-bit register with load, hold, logical shift, serial-input shift and rotate modes. It also has a multi-step command sequencer that applies one shift or rotate mode a programmed number of times, with busy/done signalling. It sits beside the register file and serialiser logic in the single-cycle datapath, and serves both as a one-op-per-cycle register and as a self-timed N-bit shifter.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of the step-count input
- RESET_VAL, all ones, value loaded into regval on reset
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  single-step enable in IDLE; stall control (0 = pause) in RUN
- mode  in  3  000 load, 001 hold, 010 shift right, 011 shift left, 100 shift right with inbit into MSB, 101 shift left with inbit into LSB, 110 rotate right, 111 rotate left
- inbit  in  1  serial input bit for modes 100/101
- loadval  in  WIDTH  value for mode 000
- start  in  1  command request, sampled only in IDLE with enable=1
- count  in  CNT_W  number of steps for the command; 0 is legal
- regval  out  WIDTH  register contents
- shout  out  1  bit shifted or rotated out by the most recent shift/rotate step
- busy  out  1  command in progress (RUN state)
- done  out  1  one-cycle pulse after the final step of a command

## Operation
- States: IDLE, RUN. Internal registers: latched mode, latched inbit, remaining-step counter rem (CNT_W bits).
- IDLE, enable=0: all state and outputs hold; done=0.
- IDLE, enable=1, start=0: one op per `mode` at this edge; done stays 0.
- IDLE, enable=1, start=1: command accepted. Latch mode and inbit.
  - count=0: no op; done=1 next cycle; stay IDLE.
  - count=1: first op at the accepting edge; done=1; stay IDLE.
  - count≥2: first op at the accepting edge; rem=count−1; go to RUN.
- RUN, enable=1: one op using the latched mode and inbit; rem decrements. When rem reaches 0, go to IDLE with done=1.
- RUN, enable=0: stall. regval, rem and shout hold; busy stays 1.
- In RUN, start, mode, inbit, count and loadval are ignored.
- Load and hold as the command mode: each step reloads loadval (sampled live) or holds.
- shout: on right shift/rotate = regval[0] before the step; on left = regval[WIDTH−1] before the step. Unchanged by load and hold.
- Counts > WIDTH are legal: shifting continues (zero/inbit fill) and rotates wrap.
- Reset dominates everything: regval=RESET_VAL, shout=0, busy=0, done=0, rem=0, state IDLE, including mid-command. No done is issued for an aborted command.

## Timing
- All outputs are registered. regval and shout update at the edge that performs the op.
- busy=1 from the edge after acceptance (count≥2) until the edge of the last step; it deasserts together with the done assertion.
- A command of N≥1 steps with no stalls occupies edges k..k+N−1. done is high in the cycle after edge k+N−1. Each stall cycle adds one edge.
- done is exactly one cycle wide. A new start is accepted while done=1.

## Configuration
- SHIFT_REG_SEQ_ARITH_EN defined: mode 010 is an arithmetic right shift; MSB refilled with the old regval[WIDTH−1].
- SHIFT_REG_SEQ_ARITH_EN undefined: mode 010 is a logical right shift with zero fill.
- All other modes are identical in both builds.

## Test plan
- Reset: rst_n=0 for one edge during any state → regval=8'hFF, shout=0, busy=0, done=0.
- Single step: load 8'hA5 (mode 000, enable=1), then one edge of mode 110 → regval=8'hD2, shout=1, done=0.
- Command:
  - Setup: load 8'h81, then start=1, mode 101, inbit=1, count=3.
  - regval steps 8'h03, 8'h07, 8'h0F; shout 1, 0, 0.
  - busy high for 2 cycles; done pulses once after the third edge.
- Stall: repeat the command scenario with enable=0 for 2 cycles after the first step → regval frozen at 8'h03, busy held, done arrives 2 cycles later, same final 8'h0F.
- Arithmetic: load 8'h90, one step of mode 010 → 8'hC8 with SHIFT_REG_SEQ_ARITH_EN, 8'h48 without; shout=0 in both.
- Edge cases:
  - Reset asserted at the second step of a count=5 command → 8'hFF, IDLE, no done.
  - start with count=0 → done pulse next cycle, regval unchanged, busy never asserted.

Source files
------------

// File: rtl/shift_reg_seq.sv
// WIDTH-bit load/shift/rotate register with a self-timed multi-step command sequencer.
// Optional build macro SHIFT_REG_SEQ_ARITH_EN turns mode 010 into an arithmetic right shift.
module shift_reg_seq #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [2:0]       i_mode,
    input  logic             i_inbit,
    input  logic [WIDTH-1:0] i_loadval,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    output logic [WIDTH-1:0] o_regval,
    output logic             o_shout,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [2:0]       r_mode;
    logic             r_inbit;
    logic [CNT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_regval;
    logic             r_shout;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_opMode;
    logic             w_opBit;
    logic [WIDTH-1:0] w_nextVal;
    logic             w_nextShout;

    // While a command runs, the latched mode/inbit drive the datapath; live inputs otherwise.
    always_comb begin
        w_opMode    = (r_state == RUN) ? r_mode : i_mode;
        w_opBit     = (r_state == RUN) ? r_inbit : i_inbit;
        w_nextVal   = r_regval;
        w_nextShout = r_shout;
        case (w_opMode)
            3'b000: w_nextVal = i_loadval;
            3'b001: w_nextVal = r_regval;
            3'b010: begin
                w_nextShout = r_regval[0];
`ifdef SHIFT_REG_SEQ_ARITH_EN
                w_nextVal   = {r_regval[WIDTH-1], r_regval[WIDTH-1:1]};
`else
                w_nextVal   = {1'b0, r_regval[WIDTH-1:1]};
`endif
            end
            3'b011: begin
                w_nextShout = r_regval[WIDTH-1];
                w_nextVal   = {r_regval[WIDTH-2:0], 1'b0};
            end
            3'b100: begin
                w_nextShout = r_regval[0];
                w_nextVal   = {w_opBit, r_regval[WIDTH-1:1]};
            end
            3'b101: begin
                w_nextShout = r_regval[WIDTH-1];
                w_nextVal   = {r_regval[WIDTH-2:0], w_opBit};
            end
            3'b110: begin
                w_nextShout = r_regval[0];
                w_nextVal   = {r_regval[0], r_regval[WIDTH-1:1]};
            end
            default: begin
                w_nextShout = r_regval[WIDTH-1];
                w_nextVal   = {r_regval[WIDTH-2:0], r_regval[WIDTH-1]};
            end
        endcase
    end

    // The accepting edge performs the first step, so rem counts only the steps still owed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_mode   <= 3'b000;
            r_inbit  <= 1'b0;
            r_rem    <= '0;
            r_regval <= RESET_VAL;
            r_shout  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_enable) begin
                        if (i_start) begin
                            r_mode  <= i_mode;
                            r_inbit <= i_inbit;
                            if (i_count == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_regval <= w_nextVal;
                                r_shout  <= w_nextShout;
                                if (i_count == CNT_W'(1)) begin
                                    r_done <= 1'b1;
                                end else begin
                                    r_rem   <= i_count - CNT_W'(1);
                                    r_state <= RUN;
                                    r_busy  <= 1'b1;
                                end
                            end
                        end else begin
                            r_regval <= w_nextVal;
                            r_shout  <= w_nextShout;
                        end
                    end
                end
                default: begin
                    if (i_enable) begin
                        r_regval <= w_nextVal;
                        r_shout  <= w_nextShout;
                        if (r_rem == CNT_W'(1)) begin
                            r_rem   <= '0;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_rem <= r_rem - CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign o_regval = r_regval;
    assign o_shout  = r_shout;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Scoreboard bench for shift_reg_seq: an arithmetic reference model queues the expected
// outputs for each edge, and an independent monitor compares them after the edge.
module tb_shift_reg_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef SHIFT_REG_SEQ_ARITH_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstN;
    logic             enable;
    logic [2:0]       mode;
    logic             inbit;
    logic [WIDTH-1:0] loadval;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] regval;
    logic             shout;
    logic             busy;
    logic             done;

    typedef struct {
        logic [7:0] val;
        logic       sh;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    logic [7:0] mVal;
    logic       mSh;
    int         mLeft;
    logic       mDone;
    logic [2:0] mMode;
    logic       mBit;

    shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .i_enable(enable),
        .i_mode(mode),
        .i_inbit(inbit),
        .i_loadval(loadval),
        .i_start(start),
        .i_count(count),
        .o_regval(regval),
        .o_shout(shout),
        .o_busy(busy),
        .o_done(done)
    );

    always #5 clk = ~clk;

    // Reference step computed with integer arithmetic; returns {shout, value}.
    function automatic logic [8:0] modelOp(input logic [2:0] m, input logic b,
                                           input logic [7:0] ld, input logic [7:0] v,
                                           input logic sh);
        int x;
        int s;
        x = int'(v);
        s = int'(sh);
        case (m)
            3'd0: x = int'(ld);
            3'd1: x = int'(v);
            3'd2: begin s = x % 2;   x = x / 2 + ((ARITH && x >= 128) ? 128 : 0); end
            3'd3: begin s = x / 128; x = (x * 2) % 256; end
            3'd4: begin s = x % 2;   x = x / 2 + int'(b) * 128; end
            3'd5: begin s = x / 128; x = (x * 2) % 256 + int'(b); end
            3'd6: begin s = x % 2;   x = x / 2 + s * 128; end
            default: begin s = x / 128; x = (x * 2) % 256 + s; end
        endcase
        return {s[0], x[7:0]};
    endfunction

    // Drives one cycle of inputs, advances the model and queues what the next edge must produce.
    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] m,
                                 input logic b, input logic [7:0] ld, input logic s,
                                 input logic [3:0] c, input string tag);
        exp_t       ex;
        logic [8:0] res;
        @(negedge clk);
        #1;
        rstN = r; enable = e; mode = m; inbit = b; loadval = ld; start = s; count = c;
        if (!r) begin
            mVal = 8'hFF; mSh = 1'b0; mLeft = 0; mDone = 1'b0;
        end else if (mLeft > 0) begin
            mDone = 1'b0;
            if (e) begin
                res = modelOp(mMode, mBit, ld, mVal, mSh);
                {mSh, mVal} = res;
                mLeft--;
                if (mLeft == 0) mDone = 1'b1;
            end
        end else begin
            mDone = 1'b0;
            if (e) begin
                if (s) begin
                    mMode = m;
                    mBit  = b;
                    if (c == 4'd0) begin
                        mDone = 1'b1;
                    end else begin
                        res = modelOp(m, b, ld, mVal, mSh);
                        {mSh, mVal} = res;
                        mLeft = int'(c) - 1;
                        if (mLeft == 0) mDone = 1'b1;
                    end
                end else begin
                    res = modelOp(m, b, ld, mVal, mSh);
                    {mSh, mVal} = res;
                end
            end
        end
        ex.val  = mVal;
        ex.sh   = mSh;
        ex.busy = (mLeft > 0);
        ex.done = mDone;
        ex.tag  = tag;
        expQ.push_back(ex);
    endtask

    task automatic checkOutput(input exp_t e);
        checkCount++;
        if (regval === e.val && shout === e.sh && busy === e.busy && done === e.done) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got regval=%h shout=%b busy=%b done=%b, expected regval=%h shout=%b busy=%b done=%b",
                     e.tag, regval, shout, busy, done, e.val, e.sh, e.busy, e.done);
        end
    endtask

    // Monitor: after every edge, compare against the entry queued for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        rstN = 1'b0; enable = 1'b0; mode = 3'd0; inbit = 1'b0;
        loadval = 8'h00; start = 1'b0; count = 4'd0;
        mVal = 8'hFF; mSh = 1'b0; mLeft = 0; mDone = 1'b0; mMode = 3'd0; mBit = 1'b0;

        applyStimulus(0, 0, 3'd0, 0, 8'h00, 0, 4'd0, "reset");
        applyStimulus(1, 0, 3'd0, 0, 8'h00, 0, 4'd0, "resetHold");

        applyStimulus(1, 1, 3'd0, 0, 8'hA5, 0, 4'd0, "loadA5");
        applyStimulus(1, 1, 3'd6, 0, 8'h00, 0, 4'd0, "rotRight");

        applyStimulus(1, 1, 3'd0, 0, 8'h81, 0, 4'd0, "cmdLoad");
        applyStimulus(1, 1, 3'd5, 1, 8'h00, 1, 4'd3, "cmdStep1");
        applyStimulus(1, 1, 3'd2, 0, 8'h55, 1, 4'd7, "cmdStep2");
        applyStimulus(1, 1, 3'd0, 0, 8'h55, 0, 4'd0, "cmdStep3");
        applyStimulus(1, 0, 3'd0, 0, 8'h00, 0, 4'd0, "cmdDone");
        applyStimulus(1, 0, 3'd0, 0, 8'h00, 0, 4'd0, "cmdAfter");

        applyStimulus(1, 1, 3'd0, 0, 8'h81, 0, 4'd0, "stallLoad");
        applyStimulus(1, 1, 3'd5, 1, 8'h00, 1, 4'd3, "stallStep1");
        applyStimulus(1, 0, 3'd3, 0, 8'h00, 1, 4'd2, "stallHold1");
        applyStimulus(1, 0, 3'd3, 0, 8'h00, 0, 4'd0, "stallHold2");
        applyStimulus(1, 1, 3'd3, 0, 8'h00, 0, 4'd0, "stallStep2");
        applyStimulus(1, 1, 3'd3, 0, 8'h00, 0, 4'd0, "stallStep3");
        applyStimulus(1, 0, 3'd0, 0, 8'h00, 0, 4'd0, "stallDone");

        applyStimulus(1, 1, 3'd0, 0, 8'h90, 0, 4'd0, "arithLoad");
        applyStimulus(1, 1, 3'd2, 0, 8'h00, 0, 4'd0, "arithShift");

        applyStimulus(1, 1, 3'd7, 0, 8'h00, 1, 4'd5, "abortStep1");
        applyStimulus(0, 1, 3'd7, 0, 8'h00, 0, 4'd0, "abortReset");
        applyStimulus(1, 0, 3'd0, 0, 8'h00, 0, 4'd0, "abortNoDone");
        applyStimulus(1, 0, 3'd0, 0, 8'h00, 0, 4'd0, "abortIdle");

        applyStimulus(1, 1, 3'd0, 0, 8'h3C, 0, 4'd0, "zeroLoad");
        applyStimulus(1, 1, 3'd6, 0, 8'h00, 1, 4'd0, "zeroStart");
        applyStimulus(1, 1, 3'd6, 0, 8'h00, 1, 4'd0, "zeroRestart");
        applyStimulus(1, 0, 3'd0, 0, 8'h00, 0, 4'd0, "zeroDone");

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 99) >= 3),
                          ($urandom_range(0, 99) >= 15),
                          3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)),
                          ($urandom_range(0, 99) < 20),
                          4'($urandom_range(0, 15)),
                          "random");
        end

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        #3;
        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
